// File: rtl/md_unit.sv
// md_unit -- execute-stage multiply/divide unit with architectural HI/LO.
//
// Launches MULT/MULTU/DIV/DIVU on the forwarded E-stage operands. The result
// is computed at launch into hi_tmp/lo_tmp, then held there while a down-counter
// models the fixed latency. HI/LO are committed on the last busy edge.
// MTHI/MTLO write D1 into HI/LO with one-cycle latency when the unit is idle.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; aborts any in-flight operation
//   D1, D2   rs / rt operands (forwarded RD1_E / RD2_E)
//   MDOp     0=MULT 1=MULTU 2=DIV 3=DIVU, sampled with Start
//   Start    one-cycle launch pulse
//   HIWrite  MTHI: HI <= D1
//   LOWrite  MTLO: LO <= D1
//   Busy     operation in flight (registered-derived, no path from Start)
//   HI, LO   architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [1:0]  MDOp,
    input  logic        Start,
    input  logic        HIWrite,
    input  logic        LOWrite,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_tmp, lo_tmp;

    // Launch-time result datapath
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0] res_hi, res_lo;
    logic        div_zero;

    assign Busy = (cnt != '0);

    always_comb begin
        prod_s   = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
        prod_u   = {32'b0, D1} * {32'b0, D2};
        div_zero = (D2 == 32'b0);

        // Signed divide via magnitudes: 0x80000000 negates to itself, which is
        // exactly its magnitude as unsigned, so the overflow case falls out
        // naturally (0x80000000 / -1 -> quotient 0x80000000, remainder 0).
        abs_a = D1[31] ? (~D1 + 32'd1) : D1;
        abs_b = D2[31] ? (~D2 + 32'd1) : D2;
        q_mag = div_zero ? 32'b0 : abs_a / abs_b;
        r_mag = div_zero ? 32'b0 : abs_a % abs_b;
        q_s   = (D1[31] ^ D2[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s   = D1[31] ? (~r_mag + 32'd1) : r_mag;   // remainder follows dividend
        q_u   = div_zero ? 32'b0 : D1 / D2;
        r_u   = div_zero ? 32'b0 : D1 % D2;

        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        case (MDOp)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
            OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
            default:  ;
        endcase
        // Divide by zero commits the current HI/LO, i.e. leaves them unchanged;
        // HI/LO cannot move while busy, so snapshotting them here is exact.
        if (MDOp[1] && div_zero) begin
            res_hi = HI;
            res_lo = LO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            HI     <= '0;
            LO     <= '0;
        end else if (Busy) begin
            // Start/HIWrite/LOWrite are ignored here so the in-flight op is safe
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                HI <= hi_tmp;
                LO <= lo_tmp;
            end
        end else if (Start) begin
            // Start beats a same-cycle move; the move is dropped
            hi_tmp <= res_hi;
            lo_tmp <= res_lo;
            cnt    <= MDOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else begin
            if (HIWrite) HI <= D1;
            if (LOWrite) LO <= D1;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D1, D2;
    logic [1:0]  MDOp;
    logic        Start, HIWrite, LOWrite;
    logic        Busy;
    logic [31:0] HI, LO;

    int nvec = 0;
    int nerr = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .D1(D1), .D2(D2), .MDOp(MDOp),
        .Start(Start), .HIWrite(HIWrite), .LOWrite(LOWrite),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op, measure Busy length, optionally inject junk at busy cycle inj
    // (Start MULT + HIWrite + LOWrite, D1=0xAAAA) and check HI/LO are held there.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input int inj);
        logic [31:0] pre_hi, pre_lo;
        int len;
        pre_hi = HI;
        pre_lo = LO;
        MDOp = op; D1 = a; D2 = b; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk({tag, "_busy_rise"}, {31'b0, Busy}, 32'd1);
        len = 0;
        while (Busy && len < 64) begin
            len++;
            if (len == inj) begin
                chk({tag, "_hold_hi"}, HI, pre_hi);
                chk({tag, "_hold_lo"}, LO, pre_lo);
                Start = 1'b1; MDOp = 2'd0; D1 = 32'h0000_AAAA; D2 = 32'd2;
                HIWrite = 1'b1; LOWrite = 1'b1;
            end
            tick();
            Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
        end
        chk({tag, "_busy_len"}, len, n);
        chk({tag, "_hi"}, HI, ehi);
        chk({tag, "_lo"}, LO, elo);
    endtask

    initial begin
        int len;
        reset = 1'b1; D1 = '0; D2 = '0; MDOp = '0;
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        // Back-to-back: each run_op starts in the first Busy=0 cycle after a commit
        run_op("mult",   2'd0, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("multu",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div",    2'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ov", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 0);

        // MTHI, then divide by zero leaves HI/LO unchanged
        D1 = 32'h0000_1234; HIWrite = 1'b1;
        tick();
        HIWrite = 1'b0;
        chk("mthi", HI, 32'h0000_1234);
        chk("mthi_lo", LO, 32'h8000_0000);
        run_op("divu0",  2'd3, 32'd7, 32'd0,                10, 32'h0000_1234, 32'h8000_0000, 0);

        // Inputs during busy ignored
        run_op("divu_ign", 2'd3, 32'd100, 32'd7,            10, 32'd2, 32'd14, 4);

        // MTHI+MTLO together
        D1 = 32'hCAFE_0001; HIWrite = 1'b1; LOWrite = 1'b1;
        tick();
        HIWrite = 1'b0; LOWrite = 1'b0;
        chk("mthilo_hi", HI, 32'hCAFE_0001);
        chk("mthilo_lo", LO, 32'hCAFE_0001);

        // Start and HIWrite together: Start wins; HI must hold old value while busy
        MDOp = 2'd1; D1 = 32'd3; D2 = 32'd3; Start = 1'b1; HIWrite = 1'b1;
        tick();
        Start = 1'b0; HIWrite = 1'b0;
        chk("stwin_busy", {31'b0, Busy}, 32'd1);
        chk("stwin_hold", HI, 32'hCAFE_0001);
        len = 0;
        while (Busy && len < 64) begin len++; tick(); end
        chk("stwin_len", len, 5);
        chk("stwin_hi", HI, 32'd0);
        chk("stwin_lo", LO, 32'd9);

        // Reset in cycle 3 of a MULT aborts it
        MDOp = 2'd0; D1 = 32'd6; D2 = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick();          // now in busy cycle 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_busy", {31'b0, Busy}, 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("rstmid_late_busy", {31'b0, Busy}, 32'd0);
        chk("rstmid_late_lo", LO, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
